// File: rtl/nios2_soc_sysid_pkg.sv
// Shared constants for the generation-2 system-ID slave: register offsets,
// CTRL bit positions and the deepest supported read pipeline.
package nios2_soc_sysid_pkg;

    localparam int unsigned REG_ID        = 0;
    localparam int unsigned REG_TIMESTAMP = 1;
    localparam int unsigned REG_UPTIME_LO = 2;
    localparam int unsigned REG_UPTIME_HI = 3;
    localparam int unsigned REG_CLKFREQ   = 4;
    localparam int unsigned REG_SCRATCH   = 5;
    localparam int unsigned REG_CTRL      = 6;

    localparam int unsigned CTRL_CLR = 0;
    localparam int unsigned CTRL_RUN = 1;

    localparam int unsigned MAX_READ_LATENCY = 2;

endpackage

// File: rtl/nios2_soc_sysid_uptime.sv
// 64-bit free-running uptime counter with a high-word shadow captured
// whenever the low word is read, so software sees a coherent 64-bit value.
module nios2_soc_sysid_uptime (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    input  logic        clr,
    input  logic        snapshot,
    output logic [31:0] lo,
    output logic [31:0] hi_shadow
);

    logic [63:0] cnt_q, cnt_d;
    logic [31:0] shadow_q, shadow_d;

    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + 64'd1;
        end
        if (snapshot) begin
            shadow_d = cnt_q[63:32];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    assign lo        = cnt_q[31:0];
    assign hi_shadow = shadow_q;

endmodule

// File: rtl/nios2_soc_sysid_ext.sv
// Avalon-MM system-ID slave (gen 2): ID/timestamp/clock words, uptime counter,
// CTRL register and a fixed-latency read pipeline. SYSID_SCRATCH_EN adds SCRATCH.
module nios2_soc_sysid_ext
    import nios2_soc_sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP    = 32'd0,
    parameter logic [31:0] CLK_FREQ_HZ  = 32'd50000000,
    parameter int unsigned ADDR_W       = 3,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    localparam int unsigned LAT = (READ_LATENCY == 0) ? 1 :
                                  (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                                  READ_LATENCY;

    logic        run_q, run_d;
    logic        ctrl_wr, clr, snapshot;
    logic [31:0] up_lo, up_hi_shadow, scratch_rd, rdata;

    nios2_soc_sysid_uptime u_uptime (
        .clock     (clock),
        .reset_n   (reset_n),
        .run       (run_q),
        .clr       (clr),
        .snapshot  (snapshot),
        .lo        (up_lo),
        .hi_shadow (up_hi_shadow)
    );

`ifdef SYSID_SCRATCH_EN
    logic [31:0] scratch_q, scratch_d;

    always_comb begin
        scratch_d = scratch_q;
        if (write && (address == ADDR_W'(REG_SCRATCH))) begin
            scratch_d = writedata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scratch_q <= '0;
        end else begin
            scratch_q <= scratch_d;
        end
    end

    assign scratch_rd = scratch_q;
`else
    logic unused_scratch_wdata;
    assign unused_scratch_wdata = ^writedata[31:2];
    assign scratch_rd           = '0;
`endif

    always_comb begin
        ctrl_wr  = write && (address == ADDR_W'(REG_CTRL));
        clr      = ctrl_wr && writedata[CTRL_CLR];
        snapshot = read && (address == ADDR_W'(REG_UPTIME_LO));
        run_d    = run_q;
        if (ctrl_wr) begin
            run_d = writedata[CTRL_RUN];
        end

        // Register values are sampled before this cycle's write lands.
        rdata = '0;
        case (address)
            ADDR_W'(REG_ID):        rdata = SYSTEM_ID;
            ADDR_W'(REG_TIMESTAMP): rdata = TIMESTAMP;
            ADDR_W'(REG_UPTIME_LO): rdata = up_lo;
            ADDR_W'(REG_UPTIME_HI): rdata = up_hi_shadow;
            ADDR_W'(REG_CLKFREQ):   rdata = CLK_FREQ_HZ;
            ADDR_W'(REG_SCRATCH):   rdata = scratch_rd;
            ADDR_W'(REG_CTRL):      rdata[CTRL_RUN] = run_q;
            default:                rdata = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b1;
        end else begin
            run_q <= run_d;
        end
    end

    logic        vld_q [LAT];
    logic        vld_d [LAT];
    logic [31:0] dat_q [LAT];
    logic [31:0] dat_d [LAT];

    always_comb begin
        vld_d[0] = read;
        dat_d[0] = read ? rdata : '0;
        for (int unsigned i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < LAT; i++) begin
                vld_q[i] <= vld_d[i];
                dat_q[i] <= dat_d[i];
            end
        end
    end

    assign readdata      = dat_q[LAT-1];
    assign readdatavalid = vld_q[LAT-1];

endmodule
